// File: rtl/led7_scan_driver_pkg.sv
// Shared constants and helpers for the 7-seg scan driver.
// Polarity helper keeps AN encoding in one place.
package led7_scan_driver_pkg;

  localparam int NIBBLE_W      = 4;
  localparam int DEF_SLOT_CYC  = 50000;
  localparam int DEF_BLANK_CYC = 500;

  // Pin level for a digit enable given the polarity.
  function automatic logic an_lvl(
    input bit act_low,
    input bit on
  );
    return act_low ? !on : on;
  endfunction

endpackage

// File: rtl/led7_tick_gen.sv
// Modulo-MOD free-running counter.
// tick marks the last count before wrap.
module led7_tick_gen #(
  parameter int MOD = 4,
  parameter int W   = $clog2(MOD)
) (
  input  logic         clk,
  input  logic         rst_n,
  output logic [W-1:0] cnt,
  output logic         tick
);

  assign tick = (cnt == W'(MOD - 1));

  // Count 0..MOD-1 and wrap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/led7_scan_driver.sv
// Scan driver for an N-digit 7-seg display.
// Double-buffered value, commit at frame wrap.
module led7_scan_driver
  import led7_scan_driver_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SLOT_CYC   = DEF_SLOT_CYC,
  parameter int BLANK_CYC  = DEF_BLANK_CYC,
  parameter bit AN_ACT_LOW = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NIBBLE_W*NUM_DIGITS-1:0] value,
  input  logic                         load,
  input  logic                         blank_lz,
  output logic [NIBBLE_W-1:0]          S,
  output logic [NUM_DIGITS-1:0]        AN,
  output logic                         frame
);

  localparam int CW = $clog2(SLOT_CYC);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int VW = NIBBLE_W * NUM_DIGITS;

  localparam logic [NUM_DIGITS-1:0] AN_IDLE =
    {NUM_DIGITS{an_lvl(AN_ACT_LOW, 1'b0)}};

  logic [CW-1:0]         slot_cnt;
  logic                  tick;
  logic [IW-1:0]         idx;
  logic                  wrap;
  logic [VW-1:0]         pending;
  logic                  pend_vld;
  logic [VW-1:0]         shown;
  logic [NUM_DIGITS-1:0] supp;
  logic                  allz;
  logic [NIBBLE_W-1:0]   nib;
  logic                  supp_cur;
  logic                  lit;
  logic [NUM_DIGITS-1:0] an_d;

  led7_tick_gen #(
    .MOD (SLOT_CYC),
    .W   (CW)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .cnt   (slot_cnt),
    .tick  (tick)
  );

  assign wrap = tick && (idx == IW'(NUM_DIGITS - 1));

  // Advance the scanned digit once per slot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx <= '0;
    end else if (tick) begin
      idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
    end
  end

  // Pending/shown buffers; a load on the wrap tick bypasses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending  <= '0;
      pend_vld <= 1'b0;
      shown    <= '0;
    end else begin
      if (load) begin
        pending  <= value;
        pend_vld <= 1'b1;
      end
      if (wrap) begin
        if (load) begin
          shown <= value;
        end else if (pend_vld) begin
          shown <= pending;
        end
        pend_vld <= 1'b0;
      end
    end
  end

  // Digit i>0 is blank when it and all above it are zero.
  always_comb begin
    supp = '0;
    allz = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      allz    = allz & (shown[NIBBLE_W*i +: NIBBLE_W] == '0);
      supp[i] = blank_lz & allz;
    end
  end

  // Select nibble and enable for the current digit.
  always_comb begin
    nib      = '0;
    supp_cur = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        nib      = shown[NIBBLE_W*i +: NIBBLE_W];
        supp_cur = supp[i];
      end
    end
    lit = (slot_cnt >= CW'(BLANK_CYC)) && !supp_cur;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      an_d[i] = an_lvl(AN_ACT_LOW, lit && (idx == IW'(i)));
    end
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      S     <= '0;
      AN    <= AN_IDLE;
      frame <= 1'b0;
    end else begin
      S     <= nib;
      AN    <= an_d;
      frame <= wrap;
    end
  end

endmodule
